// File: rtl/fetch_stage.sv
// Instruction fetch front-end: one instruction read per packet, handed to decode over a busy/recv handshake.
// Execute may redirect the PC and lane mask at any time; halt freezes fetch until reset.
module fetch_stage #(
    parameter int                  NUM_LANES  = 8,
    parameter int                  PC_WIDTH   = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  INSN_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_req_valid,
    output logic [PC_WIDTH-1:0]  mem_req_addr,
    input  logic                 mem_req_ready,
    input  logic                 mem_rsp_valid,
    input  logic [31:0]          mem_rsp_data,
    output logic                 dec_busy,
    output logic [PC_WIDTH-1:0]  dec_pc,
    output logic [31:0]          dec_insn,
    output logic [NUM_LANES-1:0] dec_exec_mask,
    input  logic                 dec_recv,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    input  logic [NUM_LANES-1:0] redirect_mask,
    input  logic                 halt,
    output logic                 halted
);

    typedef enum logic [1:0] {REQ, WAIT, SEND, HALTED} state_t;

    state_t                state_reg, state_next;
    logic [PC_WIDTH-1:0]   pc_reg, pc_next;
    logic [NUM_LANES-1:0]  mask_reg, mask_next;
    logic                  drop_reg, drop_next;
    logic [PC_WIDTH-1:0]   pkt_pc_reg, pkt_pc_next;
    logic [31:0]           pkt_insn_reg, pkt_insn_next;
    logic [NUM_LANES-1:0]  pkt_mask_reg, pkt_mask_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= REQ;
            pc_reg       <= RESET_PC;
            mask_reg     <= '1;
            drop_reg     <= 1'b0;
            pkt_pc_reg   <= '0;
            pkt_insn_reg <= '0;
            pkt_mask_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            mask_reg     <= mask_next;
            drop_reg     <= drop_next;
            pkt_pc_reg   <= pkt_pc_next;
            pkt_insn_reg <= pkt_insn_next;
            pkt_mask_reg <= pkt_mask_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        mask_next     = mask_reg;
        drop_next     = drop_reg;
        pkt_pc_next   = pkt_pc_reg;
        pkt_insn_next = pkt_insn_reg;
        pkt_mask_next = pkt_mask_reg;

        if (state_reg != HALTED && halt) begin
            state_next = HALTED;
        end else begin
            case (state_reg)
                REQ: begin
                    // A redirect here still issues the old PC; its response must be discarded.
                    if (mem_req_ready) begin
                        state_next = WAIT;
                        drop_next  = redirect_valid;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (drop_reg || redirect_valid) begin
                            state_next = REQ;
                            drop_next  = 1'b0;
                        end else begin
                            pkt_pc_next   = pc_reg;
                            pkt_insn_next = mem_rsp_data;
                            pkt_mask_next = mask_reg;
                            pc_next       = pc_reg + PC_WIDTH'(INSN_BYTES);
                            state_next    = SEND;
                        end
                    end else if (redirect_valid) begin
                        drop_next = 1'b1;
                    end
                end
                SEND: begin
                    if (dec_recv || redirect_valid) begin
                        state_next = REQ;
                    end
                end
                default: begin
                end
            endcase

            if (state_reg != HALTED && redirect_valid) begin
                pc_next   = redirect_pc;
                mask_next = redirect_mask;
            end
        end
    end

    // Request valid is held low while reset is asserted even though the state is already REQ.
    assign mem_req_valid = (state_reg == REQ) && !reset;
    assign mem_req_addr  = (state_reg == HALTED) ? '0 : pc_reg;
    assign dec_busy      = (state_reg == SEND);
    assign dec_pc        = dec_busy ? pkt_pc_reg   : '0;
    assign dec_insn      = dec_busy ? pkt_insn_reg : '0;
    assign dec_exec_mask = dec_busy ? pkt_mask_reg : '0;
    assign halted        = (state_reg == HALTED);

    recv_only_when_busy: assert property (@(posedge clk) disable iff (reset)
        dec_recv |-> (state_reg == SEND));

    rsp_only_when_expected: assert property (@(posedge clk) disable iff (reset)
        mem_rsp_valid |-> (state_reg == WAIT || state_reg == HALTED));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized soak, checked at packet level
// against a model that only tracks the next expected PC and lane mask.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        dec_busy;
    logic [63:0] dec_pc;
    logic [31:0] dec_insn;
    logic [7:0]  dec_exec_mask;
    logic        dec_recv;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [7:0]  redirect_mask;
    logic        halt;
    logic        halted;

    fetch_stage #(
        .NUM_LANES (8),
        .PC_WIDTH  (64),
        .RESET_PC  (64'd0),
        .INSN_BYTES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .dec_busy      (dec_busy),
        .dec_pc        (dec_pc),
        .dec_insn      (dec_insn),
        .dec_exec_mask (dec_exec_mask),
        .dec_recv      (dec_recv),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_mask (redirect_mask),
        .halt          (halt),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    // Memory model state, shared with the main thread for injection and cancellation.
    bit          mem_pending  = 1'b0;
    int          mem_due      = 0;
    logic [63:0] mem_addr     = '0;
    int          fixed_delay  = 1;
    bit          ready_random = 1'b0;

    // Packet-level reference: the next packet decode should see.
    logic [63:0] m_pc;
    logic [7:0]  m_mask;

    function automatic logic [31:0] insn_of(input logic [63:0] a);
        return a[31:0] ^ 32'h0000_00A5;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_pending && cyc == mem_due) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = insn_of(mem_addr);
                mem_pending   = 1'b0;
            end else begin
                mem_rsp_valid = 1'b0;
            end
            mem_req_ready = ready_random ? ($urandom_range(1) == 1) : 1'b1;
            if (mem_req_valid && mem_req_ready) begin
                mem_pending = 1'b1;
                mem_addr    = mem_req_addr;
                mem_due     = cyc + ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4)));
            end
        end
    end

    // Waits for a pending packet, optionally redirecting while none is pending, then checks it.
    task automatic get_packet(input string tag, input int redir_pct);
        int n;
        n = 0;
        while (dec_busy !== 1'b1) begin
            if (n >= 80) begin
                check({tag, "_busy_timeout"}, 64'(dec_busy), 64'd1);
                $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
                $fatal(1, "packet wait expired");
            end
            redirect_valid = 1'b0;
            if (redir_pct > 0 && int'($urandom_range(99)) < redir_pct) begin
                m_pc           = {$urandom, $urandom} & ~64'h3;
                m_mask         = 8'($urandom);
                redirect_pc    = m_pc;
                redirect_mask  = m_mask;
                redirect_valid = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        redirect_valid = 1'b0;
        check({tag, "_pc"},   dec_pc, m_pc);
        check({tag, "_insn"}, 64'(dec_insn), 64'(insn_of(m_pc)));
        check({tag, "_mask"}, 64'(dec_exec_mask), 64'(m_mask));
        $display("[TB] packet %s pc=0x%h insn=0x%h mask=0x%h", tag, dec_pc, dec_insn, dec_exec_mask);
    endtask

    // mode 0: plain ack; 1: ack with redirect; 2: redirect without ack (flush).
    task automatic ack_packet(input string tag, input int hold, input int mode,
                              input logic [63:0] rp, input logic [7:0] rm);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_busy"},  64'(dec_busy), 64'd1);
            check({tag, "_hold_pc"},    dec_pc, m_pc);
            check({tag, "_hold_insn"},  64'(dec_insn), 64'(insn_of(m_pc)));
            check({tag, "_hold_noreq"}, 64'(mem_req_valid), 64'd0);
        end
        dec_recv = (mode != 2);
        if (mode != 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = rp;
            redirect_mask  = rm;
        end
        @(negedge clk);
        dec_recv       = 1'b0;
        redirect_valid = 1'b0;
        if (mode == 0) begin
            m_pc = m_pc + 64'd4;
        end else begin
            m_pc   = rp;
            m_mask = rm;
        end
        check({tag, "_gap_busy"},  64'(dec_busy), 64'd0);
        check({tag, "_next_req"},  64'(mem_req_valid), 64'd1);
        check({tag, "_next_addr"}, mem_req_addr, m_pc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t_prev, t_now, d, o, n;
        logic [7:0] rm;
        reset = 1'b1; dec_recv = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        redirect_mask = '0; halt = 1'b0;
        m_pc = 64'd0; m_mask = 8'hFF;
        t_prev = 0;

        repeat (3) @(negedge clk);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_req_addr",  mem_req_addr, 64'd0);
        check("rst_busy",      64'(dec_busy), 64'd0);
        check("rst_dec_pc",    dec_pc, 64'd0);
        check("rst_dec_insn",  64'(dec_insn), 64'd0);
        check("rst_dec_mask",  64'(dec_exec_mask), 64'd0);
        check("rst_halted",    64'(halted), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("first_req_valid", 64'(mem_req_valid), 64'd1);
        check("first_req_addr",  mem_req_addr, 64'd0);

        // Zero-wait memory, decode acks one cycle after busy.
        for (int k = 0; k < 3; k++) begin
            get_packet($sformatf("seq%0d", k), 0);
            t_now = cyc;
            if (k > 0) check("seq_spacing", 64'(t_now - t_prev), 64'd4);
            t_prev = t_now;
            ack_packet("seq", 1, 0, '0, '0);
        end

        // Decode back-pressure; the following request gets a longer memory latency.
        get_packet("bp", 0);
        d = $urandom_range(2, 4);
        fixed_delay = d;
        ack_packet("bp", 10, 0, '0, '0);

        // Redirect while the request is outstanding.
        o = $urandom_range(1, d);
        repeat (o) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 64'h100; redirect_mask = 8'h0F;
        m_pc = 64'h100; m_mask = 8'h0F;
        @(negedge clk);
        redirect_valid = 1'b0;
        fixed_delay = 1;
        n = 0;
        while (!mem_req_valid && n < 10) begin
            check("wr_no_packet", 64'(dec_busy), 64'd0);
            @(negedge clk);
            n++;
        end
        check("wr_req_addr", mem_req_addr, 64'h100);
        get_packet("wr", 0);
        ack_packet("wr", 1, 0, '0, '0);

        // Redirect in SEND with and without a simultaneous ack.
        get_packet("sr", 0);
        rm = 8'($urandom);
        ack_packet("sr_recv", 0, 1, 64'h40, rm);
        get_packet("sr40", 0);
        ack_packet("sr40", 1, 0, '0, '0);
        get_packet("sr44", 0);
        ack_packet("sr_flush", 2, 2, 64'h200, 8'h3C);
        get_packet("sr200", 0);
        ack_packet("sr200", 0, 0, '0, '0);

        // Halt with a pending packet and a simultaneous redirect.
        get_packet("halt", 0);
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h300; redirect_mask = 8'h01;
        @(negedge clk);
        halt = 1'b0; redirect_valid = 1'b0;
        check("halt_halted",    64'(halted), 64'd1);
        check("halt_busy",      64'(dec_busy), 64'd0);
        check("halt_req_valid", 64'(mem_req_valid), 64'd0);
        check("halt_req_addr",  mem_req_addr, 64'd0);
        check("halt_dec_pc",    dec_pc, 64'd0);
        for (int i = 0; i < 6; i++) begin
            redirect_valid = 1'b1;
            redirect_pc    = {$urandom, $urandom};
            redirect_mask  = 8'($urandom);
            if (i % 2 == 0) begin
                mem_pending = 1'b1; mem_addr = {$urandom, $urandom}; mem_due = cyc + 1;
            end
            @(negedge clk);
            redirect_valid = 1'b0;
            check("halted_stays",   64'(halted), 64'd1);
            check("halted_noreq",   64'(mem_req_valid), 64'd0);
            check("halted_nobusy",  64'(dec_busy), 64'd0);
        end

        // Asynchronous reset leaves HALTED without waiting for a clock edge.
        mem_pending = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("areset_halted",    64'(halted), 64'd0);
        check("areset_req_valid", 64'(mem_req_valid), 64'd0);
        check("areset_req_addr",  mem_req_addr, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        m_pc = 64'd0; m_mask = 8'hFF;
        @(negedge clk);
        check("rst1_req_addr", mem_req_addr, 64'd0);
        get_packet("rst1", 0);
        fixed_delay = 6;
        ack_packet("rst1", 0, 0, '0, '0);

        // Reset in the middle of WAIT for the PC 4 request.
        @(negedge clk);
        #3 reset = 1'b1;
        mem_pending = 1'b0;
        #1;
        check("midwait_busy",      64'(dec_busy), 64'd0);
        check("midwait_req_valid", 64'(mem_req_valid), 64'd0);
        check("midwait_req_addr",  mem_req_addr, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        fixed_delay = 1;
        m_pc = 64'd0; m_mask = 8'hFF;
        @(negedge clk);
        check("rst2_req_valid", 64'(mem_req_valid), 64'd1);
        check("rst2_req_addr",  mem_req_addr, 64'd0);
        get_packet("rst2", 0);

        // PC wrap at the top of the address space.
        ack_packet("wrap_redir", 0, 2, 64'hFFFF_FFFF_FFFF_FFFC, 8'h5A);
        get_packet("wrap", 0);
        ack_packet("wrap", 1, 0, '0, '0);
        check("wrap_next_zero", mem_req_addr, 64'd0);
        get_packet("wrap0", 0);
        ack_packet("wrap0", 0, 0, '0, '0);

        // Randomized soak: random memory readiness/latency, ack timing and redirects.
        ready_random = 1'b1;
        fixed_delay  = 0;
        for (int k = 0; k < 40; k++) begin
            int r, mode;
            get_packet($sformatf("soak%0d", k), 4);
            r = $urandom_range(9);
            mode = (r < 7) ? 0 : ((r < 8) ? 1 : 2);
            ack_packet("soak", $urandom_range(0, 3), mode,
                       {$urandom, $urandom} & ~64'h3, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
